// File: rtl/ascensor_pkg.sv
// rtl/ascensor_pkg.sv - shared state encoding and direction constants for the elevator scheduler
// Purpose: types and constants imported by controlador_ascensor.
// Ports: none (package).
package ascensor_pkg;

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        SUBIENDO = 2'd1,
        BAJANDO  = 2'd2,
        PUERTA   = 2'd3
    } estado_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/buscador_solicitudes.sv
// rtl/buscador_solicitudes.sv - classifies pending requests as above, below or at the current floor
// Purpose: combinational request search for any number of floors.
// Ports:
//   i_s      pending request bits, bit i = floor i
//   i_piso   current floor index
//   o_arriba some request strictly above i_piso
//   o_abajo  some request strictly below i_piso
//   o_aqui   request pending at i_piso
module buscador_solicitudes #(
    parameter int N_PISOS = 4,
    parameter int W_PISO  = $clog2(N_PISOS)
) (
    input  logic [N_PISOS-1:0] i_s,
    input  logic [W_PISO-1:0]  i_piso,
    output logic               o_arriba,
    output logic               o_abajo,
    output logic               o_aqui
);

    // Equality compare instead of i_s[i_piso] so an out-of-range floor code
    // (non power-of-two N_PISOS) reads as "no request" rather than X.
    always_comb begin
        o_arriba = 1'b0;
        o_abajo  = 1'b0;
        o_aqui   = 1'b0;
        for (int j = 0; j < N_PISOS; j++) begin
            if (j > int'(i_piso))  o_arriba = o_arriba | i_s[j];
            if (j < int'(i_piso))  o_abajo  = o_abajo  | i_s[j];
            if (j == int'(i_piso)) o_aqui   = o_aqui   | i_s[j];
        end
    end

endmodule

// File: rtl/controlador_ascensor.sv
// rtl/controlador_ascensor.sv - SCAN scheduler driving motor direction and door for one car
// Purpose: decides travel direction, stops at requested floors, times the door and
//          pulses the serviced floor back to the request latches.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   s         pending requests (level), piso current floor, llegada floor-aligned pulse
//   obst      door obstruction (level)
//   subir/bajar motor up/down, puerta door open, apagar one-hot clear pulse, dir SCAN direction
module controlador_ascensor
    import ascensor_pkg::*;
#(
    parameter int N_PISOS     = 4,
    parameter int DOOR_CYCLES = 8,
    localparam int W_PISO     = $clog2(N_PISOS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_PISOS-1:0] s,
    input  logic [W_PISO-1:0]  piso,
    input  logic               llegada,
    input  logic               obst,
    output logic               subir,
    output logic               bajar,
    output logic               puerta,
    output logic [N_PISOS-1:0] apagar,
    output logic               dir
);

    localparam int W_CNT = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [W_CNT-1:0]  CNT_CARGA = W_CNT'(DOOR_CYCLES - 1);
    localparam logic [W_PISO-1:0] PISO_TOPE = W_PISO'(N_PISOS - 1);

    estado_t            r_estado;
    logic               r_subir;
    logic               r_bajar;
    logic               r_puerta;
    logic [N_PISOS-1:0] r_apagar;
    logic               r_dir;
    logic [W_CNT-1:0]   r_cnt;

    estado_t            w_estado_sig;
    logic               w_dir_sig;
    logic [W_CNT-1:0]   w_cnt_sig;
    logic               w_servir;
    logic               w_arriba;
    logic               w_abajo;
    logic               w_aqui;
    logic [N_PISOS-1:0] w_piso_onehot;

    buscador_solicitudes #(
        .N_PISOS (N_PISOS),
        .W_PISO  (W_PISO)
    ) u_buscador (
        .i_s      (s),
        .i_piso   (piso),
        .o_arriba (w_arriba),
        .o_abajo  (w_abajo),
        .o_aqui   (w_aqui)
    );

    assign w_piso_onehot = {{(N_PISOS-1){1'b0}}, 1'b1} << piso;

    always_comb begin
        w_estado_sig = r_estado;
        w_dir_sig    = r_dir;
        w_servir     = 1'b0;
        w_cnt_sig    = r_cnt;
        unique case (r_estado)
            REPOSO: begin
                if (w_aqui) begin
                    w_estado_sig = PUERTA;
                    w_servir     = 1'b1;
                end else if (w_arriba && (r_dir || !w_abajo)) begin
                    w_estado_sig = SUBIENDO;
                    w_dir_sig    = DIR_UP;
                end else if (w_abajo) begin
                    w_estado_sig = BAJANDO;
                    w_dir_sig    = DIR_DOWN;
                end
            end
            SUBIENDO: begin
                if (llegada) begin
                    if (w_aqui) begin
                        w_estado_sig = PUERTA;
                        w_servir     = 1'b1;
                    end else if (piso == PISO_TOPE) begin
                        w_estado_sig = REPOSO;
                    end
                end
            end
            BAJANDO: begin
                if (llegada) begin
                    if (w_aqui) begin
                        w_estado_sig = PUERTA;
                        w_servir     = 1'b1;
                    end else if (piso == '0) begin
                        w_estado_sig = REPOSO;
                    end
                end
            end
            PUERTA: begin
                // Re-requests are only honoured once the door is open and the
                // previous pulse is gone, so a latch that clears one cycle late
                // cannot trigger a duplicate clear.
                if (r_puerta && w_aqui && (r_apagar == '0)) begin
                    w_servir = 1'b1;
                end else if (obst) begin
                    w_cnt_sig = CNT_CARGA;
                end else if (r_puerta && (r_cnt == '0)) begin
                    if (r_dir == DIR_UP) begin
                        if (w_arriba) begin
                            w_estado_sig = SUBIENDO;
                        end else if (w_abajo) begin
                            w_estado_sig = BAJANDO;
                            w_dir_sig    = DIR_DOWN;
                        end else begin
                            w_estado_sig = REPOSO;
                        end
                    end else begin
                        if (w_abajo) begin
                            w_estado_sig = BAJANDO;
                        end else if (w_arriba) begin
                            w_estado_sig = SUBIENDO;
                            w_dir_sig    = DIR_UP;
                        end else begin
                            w_estado_sig = REPOSO;
                        end
                    end
                end else if (r_puerta) begin
                    // The countdown only runs while the door is actually open,
                    // giving exactly DOOR_CYCLES open cycles.
                    w_cnt_sig = r_cnt - 1'b1;
                end
            end
            default: w_estado_sig = REPOSO;
        endcase
        if (w_servir) w_cnt_sig = CNT_CARGA;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado <= REPOSO;
            r_subir  <= 1'b0;
            r_bajar  <= 1'b0;
            r_puerta <= 1'b0;
            r_apagar <= '0;
            r_dir    <= DIR_UP;
            r_cnt    <= '0;
        end else begin
            r_estado <= w_estado_sig;
            r_dir    <= w_dir_sig;
            r_cnt    <= w_cnt_sig;
            r_subir  <= (w_estado_sig == SUBIENDO);
            r_bajar  <= (w_estado_sig == BAJANDO);
            // Door opens one cycle after PUERTA entry and closes on the exit edge.
            r_puerta <= (w_estado_sig == PUERTA) && (r_estado == PUERTA);
            r_apagar <= w_servir ? w_piso_onehot : '0;
        end
    end

    assign subir  = r_subir;
    assign bajar  = r_bajar;
    assign puerta = r_puerta;
    assign apagar = r_apagar;
    assign dir    = r_dir;

endmodule

// File: tb/tb_controlador_ascensor.sv
// tb/tb_controlador_ascensor.sv - scenario bench for controlador_ascensor with apagar scoreboard
module tb_controlador_ascensor;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] s;
    logic [1:0] piso;
    logic       llegada;
    logic       obst;
    logic       subir;
    logic       bajar;
    logic       puerta;
    logic [3:0] apagar;
    logic       dir;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [3:0] sb_q[$];
    logic [3:0] sb_e;
    bit         mon_on = 1'b0;

    always #5 clk = ~clk;

    controlador_ascensor #(
        .N_PISOS     (4),
        .DOOR_CYCLES (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s       (s),
        .piso    (piso),
        .llegada (llegada),
        .obst    (obst),
        .subir   (subir),
        .bajar   (bajar),
        .puerta  (puerta),
        .apagar  (apagar),
        .dir     (dir)
    );

    always @(negedge clk) begin
        if (mon_on) begin
            n_cmp++;
            if ((subir && bajar) || ((subir || bajar) && puerta) || !$onehot0(apagar)) begin
                n_err++;
                $display("FAIL invariants subir=%b bajar=%b puerta=%b apagar=%b", subir, bajar, puerta, apagar);
            end
            if (apagar !== 4'b0000) begin
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL apagar_unexpected got=%b expected=none", apagar);
                end else begin
                    sb_e = sb_q.pop_front();
                    if (apagar !== sb_e) begin
                        n_err++;
                        $display("FAIL apagar_scoreboard got=%b expected=%b", apagar, sb_e);
                    end
                end
            end
        end
    end

    task automatic ciclo();
        @(negedge clk);
    endtask

    task automatic llegar(input logic [1:0] p);
        piso    = p;
        llegada = 1'b1;
        ciclo();
        llegada = 1'b0;
    endtask

    task automatic medir_puerta(input int esperado, input string nombre);
        int espera = 0;
        int largo  = 0;
        while (puerta !== 1'b1 && espera < 20) begin
            ciclo();
            espera++;
        end
        while (puerta === 1'b1 && largo < 40) begin
            largo++;
            ciclo();
        end
        n_cmp++;
        if (largo != esperado) begin
            n_err++;
            $display("FAIL %s door_cycles got=%0d expected=%0d", nombre, largo, esperado);
        end
    endtask

    task automatic chk_idle(input string nombre);
        n_cmp++;
        if ({subir, bajar, puerta, apagar} !== 7'b0) begin
            n_err++;
            $display("FAIL %s idle got=%b expected=0000000", nombre, {subir, bajar, puerta, apagar});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; s = 4'b1111; piso = 2'd0; llegada = 1'b0; obst = 1'b0;
        ciclo();
        ciclo();
        n_cmp++;
        if ({subir, bajar, puerta, apagar} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_outputs got=%b expected=0000000", {subir, bajar, puerta, apagar});
        end
        n_cmp++;
        if (dir !== 1'b1) begin n_err++; $display("FAIL reset_dir got=%b expected=1", dir); end
        s = 4'b0000; rst = 1'b0; mon_on = 1'b1;
        ciclo();
        ciclo();
        chk_idle("reset_release");
    endtask

    task automatic test_servicio_local();
        piso = 2'd0;
        sb_q.push_back(4'b0001);
        s = 4'b0001;
        ciclo();
        n_cmp++;
        if ({apagar, puerta} !== 5'b00010) begin
            n_err++;
            $display("FAIL local_entry got=%b expected=00010", {apagar, puerta});
        end
        s = 4'b0000;
        medir_puerta(4, "local_door");
        chk_idle("local_after");
    endtask

    task automatic test_subida();
        piso = 2'd0;
        s = 4'b0100;
        ciclo();
        n_cmp++;
        if ({subir, dir} !== 2'b11) begin n_err++; $display("FAIL up_start got=%b expected=11", {subir, dir}); end
        llegar(2'd1);
        n_cmp++;
        if (subir !== 1'b1) begin n_err++; $display("FAIL up_pass_floor1 got=%b expected=1", subir); end
        sb_q.push_back(4'b0100);
        llegar(2'd2);
        n_cmp++;
        if ({subir, apagar} !== 5'b00100) begin
            n_err++;
            $display("FAIL up_arrive got=%b expected=00100", {subir, apagar});
        end
        s = 4'b0000;
        medir_puerta(4, "up_door");
        chk_idle("up_after");
    endtask

    task automatic test_scan_reversal();
        sb_q.push_back(4'b0100);
        s = 4'b0100;
        ciclo();
        s = 4'b1001;
        medir_puerta(4, "scan_door2");
        n_cmp++;
        if ({subir, bajar, dir} !== 3'b101) begin
            n_err++;
            $display("FAIL scan_continue_up got=%b expected=101", {subir, bajar, dir});
        end
        sb_q.push_back(4'b1000);
        llegar(2'd3);
        n_cmp++;
        if (subir !== 1'b0) begin n_err++; $display("FAIL scan_stop3 got=%b expected=0", subir); end
        s = 4'b0001;
        medir_puerta(4, "scan_door3");
        n_cmp++;
        if ({subir, bajar, dir} !== 3'b010) begin
            n_err++;
            $display("FAIL scan_reverse got=%b expected=010", {subir, bajar, dir});
        end
        llegar(2'd2);
        llegar(2'd1);
        n_cmp++;
        if (bajar !== 1'b1) begin n_err++; $display("FAIL scan_pass_down got=%b expected=1", bajar); end
        sb_q.push_back(4'b0001);
        llegar(2'd0);
        n_cmp++;
        if (bajar !== 1'b0) begin n_err++; $display("FAIL scan_stop0 got=%b expected=0", bajar); end
        s = 4'b0000;
        medir_puerta(4, "scan_door0");
        chk_idle("scan_after");
    endtask

    task automatic test_obstruccion();
        int largo = 0;
        int espera = 0;
        sb_q.push_back(4'b0001);
        s = 4'b0001;
        ciclo();
        s = 4'b0000;
        while (puerta !== 1'b1 && espera < 20) begin ciclo(); espera++; end
        obst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ciclo();
            n_cmp++;
            if (puerta !== 1'b1) begin n_err++; $display("FAIL obst_hold cycle=%0d got=%b expected=1", i, puerta); end
        end
        obst = 1'b0;
        while (puerta === 1'b1 && largo < 40) begin largo++; ciclo(); end
        n_cmp++;
        if (largo != 4) begin n_err++; $display("FAIL obst_tail got=%0d expected=4", largo); end
        chk_idle("obst_after");
    endtask

    task automatic test_back_to_back();
        sb_q.push_back(4'b0001);
        s = 4'b0001;
        ciclo();
        s = 4'b0000;
        ciclo();
        ciclo();
        sb_q.push_back(4'b0001);
        s = 4'b0001;
        ciclo();
        n_cmp++;
        if ({apagar, puerta} !== 5'b00011) begin
            n_err++;
            $display("FAIL rerequest_pulse got=%b expected=00011", {apagar, puerta});
        end
        s = 4'b0000;
        medir_puerta(4, "rerequest_reload");
        chk_idle("rerequest_after");
    endtask

    task automatic test_fin_de_foso();
        s = 4'b1000;
        ciclo();
        n_cmp++;
        if ({subir, dir} !== 2'b11) begin n_err++; $display("FAIL guard_start got=%b expected=11", {subir, dir}); end
        s = 4'b0000;
        llegar(2'd1);
        n_cmp++;
        if (subir !== 1'b1) begin n_err++; $display("FAIL guard_keep_moving got=%b expected=1", subir); end
        llegar(2'd3);
        chk_idle("guard_stop");
        ciclo();
        chk_idle("guard_stay");
    endtask

    task automatic test_reset_en_marcha();
        s = 4'b0001;
        ciclo();
        n_cmp++;
        if ({bajar, dir} !== 2'b10) begin n_err++; $display("FAIL midreset_moving got=%b expected=10", {bajar, dir}); end
        rst = 1'b1;
        ciclo();
        n_cmp++;
        if ({subir, bajar, puerta, dir} !== 4'b0001) begin
            n_err++;
            $display("FAIL midreset_clear got=%b expected=0001", {subir, bajar, puerta, dir});
        end
        rst = 1'b0;
        s = 4'b0000;
        ciclo();
        chk_idle("midreset_after");
    endtask

    initial begin
        test_reset();
        test_servicio_local();
        test_subida();
        test_scan_reversal();
        test_obstruccion();
        test_back_to_back();
        test_fin_de_foso();
        test_reset_en_marcha();
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain got=%0d expected=0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
